// File: rtl/reg_file_scoreboard_if.sv
// rtl/reg_file_scoreboard_if.sv - decode/write-back bus of the register file scoreboard
//
// Groups every non-clock, non-reset signal of reg_file_scoreboard.
//   master : pipeline side (decode issues, write-back stage writes, reads RD/STALL)
//   slave  : the register file scoreboard itself
// Signals:
//   RA1/RA2, USE1/USE2       read addresses and "operand actually used" qualifiers
//   RD1/RD2                  forwarded read data
//   ISSUE/ISSUE_WE/ISSUE_WA  issuing instruction and its destination
//   STALL                    issue refused this cycle
//   WB_EN/WB_WA/WB_WD        write-back port
//   BUSY_CNT/WB_ERR          pending-write population and sticky stray-write-back flag
interface reg_file_scoreboard_if #(
    parameter int DW = 32
);
    logic [4:0]    RA1;
    logic [4:0]    RA2;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic          USE1;
    logic          USE2;
    logic          ISSUE;
    logic          ISSUE_WE;
    logic [4:0]    ISSUE_WA;
    logic          STALL;
    logic          WB_EN;
    logic [4:0]    WB_WA;
    logic [DW-1:0] WB_WD;
    logic [5:0]    BUSY_CNT;
    logic          WB_ERR;

    modport master (
        output RA1, RA2, USE1, USE2, ISSUE, ISSUE_WE, ISSUE_WA,
        output WB_EN, WB_WA, WB_WD,
        input  RD1, RD2, STALL, BUSY_CNT, WB_ERR
    );

    modport slave (
        input  RA1, RA2, USE1, USE2, ISSUE, ISSUE_WE, ISSUE_WA,
        input  WB_EN, WB_WA, WB_WD,
        output RD1, RD2, STALL, BUSY_CNT, WB_ERR
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - MIPS register file with pending-write scoreboard
//
// Two combinational forwarded read ports, one write-back port, and a per-register
// busy bit set when a writing instruction issues and cleared when its write-back
// arrives. STALL refuses an issue whose sources (RAW) or destination (WAW) are
// still pending. A write-back in the current cycle resolves the hazard in that
// same cycle via forwarding.
// Ports:
//   CLK   clock, all state on the rising edge
//   RSTN  asynchronous active-low reset
//   bus   reg_file_scoreboard_if.slave (reads, issue, write-back, status)
module reg_file_scoreboard #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    reg_file_scoreboard_if.slave bus
);

    // Entry 0 exists only to keep indexing uniform; it is never written and
    // resets to zero, so it behaves as no storage.
    logic [DW-1:0]   regs_q [0:NREG-1];
    logic [DW-1:0]   regs_d [0:NREG-1];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [5:0]      busy_cnt_q;
    logic [5:0]      busy_cnt_d;
    logic            wb_err_q;
    logic            wb_err_d;

    logic            wb_any;
    logic [NREG-1:0] wb_dec;
    logic [NREG-1:0] busy_eff;
    logic            stall;
    logic            set_any;
    logic [NREG-1:0] set_dec;
    logic            cnt_inc;
    logic            cnt_dec;
    logic [DW-1:0]   rd1;
    logic [DW-1:0]   rd2;

    // Write-back hit decode; writes to $0 are discarded and never match.
    always_comb begin
        wb_any = bus.WB_EN && (bus.WB_WA != 5'd0);
        wb_dec = '0;
        if (wb_any) begin
            wb_dec[bus.WB_WA] = 1'b1;
        end
    end

    // A same-cycle write-back hides the busy bit it is about to clear.
    assign busy_eff = busy_q & ~wb_dec;

    always_comb begin
        stall = bus.ISSUE && ((bus.USE1     && busy_eff[bus.RA1]) ||
                              (bus.USE2     && busy_eff[bus.RA2]) ||
                              (bus.ISSUE_WE && busy_eff[bus.ISSUE_WA]));
    end

    always_comb begin
        set_any = bus.ISSUE && !stall && bus.ISSUE_WE && (bus.ISSUE_WA != 5'd0);
        set_dec = '0;
        if (set_any) begin
            set_dec[bus.ISSUE_WA] = 1'b1;
        end
    end

    // Read ports with same-cycle write-back forwarding.
    always_comb begin
        if (bus.RA1 == 5'd0) begin
            rd1 = '0;
        end else if (wb_dec[bus.RA1]) begin
            rd1 = bus.WB_WD;
        end else begin
            rd1 = regs_q[bus.RA1];
        end
        if (bus.RA2 == 5'd0) begin
            rd2 = '0;
        end else if (wb_dec[bus.RA2]) begin
            rd2 = bus.WB_WD;
        end else begin
            rd2 = regs_q[bus.RA2];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_any) begin
            regs_d[bus.WB_WA] = bus.WB_WD;
        end
        regs_d[0] = '0;
    end

    // Set wins over a same-cycle clear of the same register.
    assign busy_d = (busy_q & ~wb_dec) | set_dec;

    // Incremental population count. An accepted set can only target a register
    // that is busy when the same cycle also writes it back; that pair nets to 0,
    // which both terms below reflect (no increment, no decrement).
    always_comb begin
        cnt_inc    = set_any && !busy_q[bus.ISSUE_WA];
        cnt_dec    = wb_any && busy_q[bus.WB_WA] && !set_dec[bus.WB_WA];
        busy_cnt_d = busy_cnt_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
    end

    // Data is still written on a stray write-back; only the flag records it.
    assign wb_err_d = wb_err_q || (wb_any && !busy_q[bus.WB_WA]);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign bus.RD1      = rd1;
    assign bus.RD2      = rd2;
    assign bus.STALL    = stall;
    assign bus.BUSY_CNT = busy_cnt_q;
    assign bus.WB_ERR   = wb_err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_fail;

    reg_file_scoreboard_if #(.DW(32)) bus ();

    reg_file_scoreboard #(.DW(32), .NREG(32)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        use1;
        logic        use2;
        logic        issue;
        logic        iwe;
        logic [4:0]  iwa;
        logic        wben;
        logic [4:0]  wbwa;
        logic [31:0] wbwd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic [5:0]  cnt;
        logic        err;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.RA1 = 5'd0; bus.RA2 = 5'd0; bus.USE1 = 1'b0; bus.USE2 = 1'b0;
        bus.ISSUE = 1'b0; bus.ISSUE_WE = 1'b0; bus.ISSUE_WA = 5'd0;
        bus.WB_EN = 1'b0; bus.WB_WA = 5'd0; bus.WB_WD = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //            ra1 ra2 u1 u2 is we iwa  wb wwa wd             rd1            rd2           st cnt er
        tbl[0]  = '{5,  0,  0, 0, 0, 0, 0,   0, 0,  32'h0,         32'h0,         32'h0,        0, 0, 0};
        tbl[1]  = '{0,  0,  0, 0, 1, 1, 8,   0, 0,  32'h0,         32'h0,         32'h0,        0, 0, 0};
        tbl[2]  = '{8,  0,  1, 0, 1, 0, 0,   0, 0,  32'h0,         32'h0,         32'h0,        1, 1, 0};
        tbl[3]  = '{8,  0,  1, 0, 1, 0, 0,   1, 8,  32'h1234_5678, 32'h1234_5678, 32'h0,        0, 1, 0};
        tbl[4]  = '{8,  0,  0, 0, 0, 0, 0,   0, 0,  32'h0,         32'h1234_5678, 32'h0,        0, 0, 0};
        tbl[5]  = '{0,  0,  0, 0, 1, 1, 3,   0, 0,  32'h0,         32'h0,         32'h0,        0, 0, 0};
        tbl[6]  = '{0,  0,  0, 0, 1, 1, 3,   1, 3,  32'hAAAA,      32'h0,         32'h0,        0, 1, 0};
        tbl[7]  = '{3,  3,  0, 0, 0, 0, 0,   0, 0,  32'h0,         32'hAAAA,      32'hAAAA,     0, 1, 0};
        tbl[8]  = '{3,  0,  1, 0, 1, 0, 0,   0, 0,  32'h0,         32'hAAAA,      32'h0,        1, 1, 0};
        tbl[9]  = '{3,  0,  0, 0, 0, 0, 0,   1, 3,  32'hBBBB,      32'hBBBB,      32'h0,        0, 1, 0};
        tbl[10] = '{3,  0,  0, 0, 0, 0, 0,   0, 0,  32'h0,         32'hBBBB,      32'h0,        0, 0, 0};
        tbl[11] = '{0,  0,  0, 0, 1, 1, 0,   0, 0,  32'h0,         32'h0,         32'h0,        0, 0, 0};
        tbl[12] = '{0,  0,  1, 0, 1, 0, 0,   1, 0,  32'hFFFF_FFFF, 32'h0,         32'h0,        0, 0, 0};
        tbl[13] = '{0,  0,  1, 1, 1, 1, 0,   0, 0,  32'h0,         32'h0,         32'h0,        0, 0, 0};
        tbl[14] = '{0,  0,  0, 0, 1, 1, 9,   0, 0,  32'h0,         32'h0,         32'h0,        0, 0, 0};
        tbl[15] = '{0,  0,  0, 0, 1, 1, 9,   0, 0,  32'h0,         32'h0,         32'h0,        1, 1, 0};
        tbl[16] = '{0,  9,  0, 1, 1, 0, 0,   0, 0,  32'h0,         32'h0,         32'h0,        1, 1, 0};
        tbl[17] = '{0,  9,  0, 1, 0, 0, 0,   1, 9,  32'h99,        32'h0,         32'h99,       0, 1, 0};
        tbl[18] = '{0,  9,  0, 0, 0, 0, 0,   0, 0,  32'h0,         32'h0,         32'h99,       0, 0, 0};
        tbl[19] = '{0,  0,  0, 0, 1, 1, 10,  0, 0,  32'h0,         32'h0,         32'h0,        0, 0, 0};
        tbl[20] = '{10, 10, 0, 0, 1, 0, 0,   0, 0,  32'h0,         32'h0,         32'h0,        0, 1, 0};
        tbl[21] = '{0,  0,  0, 0, 0, 0, 0,   1, 10, 32'h10,        32'h0,         32'h0,        0, 1, 0};
        tbl[22] = '{10, 0,  0, 0, 0, 0, 0,   0, 0,  32'h0,         32'h10,        32'h0,        0, 0, 0};

        idle();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.RA1 = tbl[i].ra1; bus.RA2 = tbl[i].ra2;
            bus.USE1 = tbl[i].use1; bus.USE2 = tbl[i].use2;
            bus.ISSUE = tbl[i].issue; bus.ISSUE_WE = tbl[i].iwe; bus.ISSUE_WA = tbl[i].iwa;
            bus.WB_EN = tbl[i].wben; bus.WB_WA = tbl[i].wbwa; bus.WB_WD = tbl[i].wbwd;
            #2;
            chk($sformatf("v%0d rd1", i),   bus.RD1, tbl[i].rd1);
            chk($sformatf("v%0d rd2", i),   bus.RD2, tbl[i].rd2);
            chk($sformatf("v%0d stall", i), {31'd0, bus.STALL}, {31'd0, tbl[i].stall});
            chk($sformatf("v%0d cnt", i),   {26'd0, bus.BUSY_CNT}, {26'd0, tbl[i].cnt});
            chk($sformatf("v%0d err", i),   {31'd0, bus.WB_ERR}, {31'd0, tbl[i].err});
            next_cycle();
        end

        // Fill 1..31 on consecutive cycles, then drain.
        idle();
        for (int a = 1; a < 32; a++) begin
            bus.ISSUE = 1'b1; bus.ISSUE_WE = 1'b1; bus.ISSUE_WA = a[4:0];
            #2;
            chk($sformatf("fill%0d stall", a), {31'd0, bus.STALL}, 32'd0);
            chk($sformatf("fill%0d cnt", a), {26'd0, bus.BUSY_CNT}, a - 1);
            next_cycle();
        end
        idle();
        #2;
        chk("full cnt", {26'd0, bus.BUSY_CNT}, 32'd31);
        for (int a = 1; a < 32; a++) begin
            bus.WB_EN = 1'b1; bus.WB_WA = a[4:0]; bus.WB_WD = 32'hC0DE_0000 | a;
            next_cycle();
            #2;
            chk($sformatf("drain%0d cnt", a), {26'd0, bus.BUSY_CNT}, 31 - a);
        end
        idle();
        for (int a = 1; a < 32; a++) begin
            bus.RA1 = a[4:0]; bus.RA2 = 5'(32 - a);
            #1;
            chk($sformatf("hold%0d rd1", a), bus.RD1, 32'hC0DE_0000 | a);
            chk($sformatf("hold%0d rd2", a), bus.RD2, 32'hC0DE_0000 | (32 - a));
        end
        chk("drain err", {31'd0, bus.WB_ERR}, 32'd0);
        next_cycle();

        // Stray write-back, sticky error, async reset clear.
        idle();
        bus.WB_EN = 1'b1; bus.WB_WA = 5'd12; bus.WB_WD = 32'h5A5A_5A5A;
        next_cycle();
        idle();
        bus.RA1 = 5'd12;
        bus.ISSUE = 1'b1; bus.ISSUE_WE = 1'b1; bus.ISSUE_WA = 5'd20;
        #2;
        chk("stray err", {31'd0, bus.WB_ERR}, 32'd1);
        chk("stray data", bus.RD1, 32'h5A5A_5A5A);
        next_cycle();
        idle();
        bus.RA1 = 5'd12;
        #2;
        chk("stray err held", {31'd0, bus.WB_ERR}, 32'd1);
        chk("pending cnt", {26'd0, bus.BUSY_CNT}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst err", {31'd0, bus.WB_ERR}, 32'd0);
        chk("rst cnt", {26'd0, bus.BUSY_CNT}, 32'd0);
        chk("rst rd1", bus.RD1, 32'd0);
        next_cycle();
        rstn = 1'b1;
        bus.RA1 = 5'd0;
        bus.WB_EN = 1'b1; bus.WB_WA = 5'd20; bus.WB_WD = 32'h2020;
        next_cycle();
        idle();
        bus.RA1 = 5'd20;
        #2;
        chk("late wb err", {31'd0, bus.WB_ERR}, 32'd1);
        chk("late wb data", bus.RD1, 32'h2020);
        chk("late wb cnt", {26'd0, bus.BUSY_CNT}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
